// File: rtl/ram_arb_pkg.sv
// Shared constants and types for the RAM port arbiter.
// The request bundle type uses the default address/data widths of the arbiter.
package ram_arb_pkg;

  localparam int MAX_REQ     = 8;
  localparam int DEF_WIDTHAD = 16;
  localparam int DEF_WIDTH   = 32;

  typedef struct packed {
    logic                   we;
    logic [DEF_WIDTHAD-1:0] addr;
    logic [DEF_WIDTH-1:0]   wdata;
  } ram_req_t;

  typedef enum logic {
    OPEN   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: the first requester after
// last_grant (wrapping) wins; outputs a one-hot grant plus its index.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int cand;

  // Scan farthest-to-nearest so the nearest valid requester is written last.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int k = N; k >= 1; k--) begin
      cand = (int'(last_grant) + k) % N;
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        idx         = IW'(cand);
        any         = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among NUM_REQ requesters, with
// 1-cycle read-response routing. Define ARB_LOCK_EN to add req_lock bus locking.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTHAD = DEF_WIDTHAD,
  parameter int WIDTH   = DEF_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_we,
  input  logic [NUM_REQ*WIDTHAD-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [WIDTH-1:0]           rsp_rdata,
  output logic [WIDTHAD-1:0]         ram_address,
  output logic                       ram_wren,
  output logic [WIDTH-1:0]           ram_data,
  output logic                       ram_rden,
  input  logic [WIDTH-1:0]           ram_q
`ifdef ARB_LOCK_EN
  ,
  input  logic [NUM_REQ-1:0]         req_lock
`endif
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  generate
    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
      $error("ram_port_arbiter: NUM_REQ must be within 2..8");
    end
  endgenerate

  logic [IW-1:0]      last_grant;
  logic [NUM_REQ-1:0] elig;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic               win_we;
  logic [WIDTHAD-1:0] win_addr;
  logic [WIDTH-1:0]   win_data;
  logic [WIDTHAD-1:0] held_addr;
  logic [WIDTH-1:0]   held_data;
  logic               tag_valid;
  logic [IW-1:0]      tag_idx;

`ifdef ARB_LOCK_EN
  lock_state_t lock_state;
  logic [IW-1:0] lock_owner;
  logic          lock_hold;

  // A lock only masks others while its owner keeps req_lock high, so the
  // release cycle is already open to everyone.
  always_comb begin
    lock_hold = (lock_state == LOCKED) && req_lock[lock_owner];
    if (rst) begin
      elig = '0;
    end else if (lock_hold) begin
      elig = req_valid & (NUM_REQ'(1) << lock_owner);
    end else begin
      elig = req_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_state <= OPEN;
      lock_owner <= '0;
    end else begin
      case (lock_state)
        OPEN: begin
          if (pick_any && req_lock[pick_idx]) begin
            lock_state <= LOCKED;
            lock_owner <= pick_idx;
          end
        end
        LOCKED: begin
          if (pick_any && req_lock[pick_idx]) begin
            lock_owner <= pick_idx;
          end else if (!req_lock[lock_owner]) begin
            lock_state <= OPEN;
          end
        end
        default: lock_state <= OPEN;
      endcase
    end
  end
`else
  always_comb begin
    if (rst) begin
      elig = '0;
    end else begin
      elig = req_valid;
    end
  end
`endif

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req        (elig),
    .last_grant (last_grant),
    .grant      (req_ready),
    .idx        (pick_idx),
    .any        (pick_any)
  );

  // Winner's request; address/data fall back to the last granted values when idle.
  always_comb begin
    win_we   = req_we[pick_idx];
    win_addr = req_addr[pick_idx*WIDTHAD +: WIDTHAD];
    win_data = req_wdata[pick_idx*WIDTH +: WIDTH];
    if (pick_any) begin
      ram_address = win_addr;
      ram_data    = win_data;
      ram_wren    = win_we;
      ram_rden    = ~win_we;
    end else begin
      ram_address = held_addr;
      ram_data    = held_data;
      ram_wren    = 1'b0;
      ram_rden    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= IW'(NUM_REQ - 1);
      held_addr  <= '0;
      held_data  <= '0;
      tag_valid  <= 1'b0;
      tag_idx    <= '0;
    end else begin
      if (pick_any) begin
        last_grant <= pick_idx;
        held_addr  <= win_addr;
        held_data  <= win_data;
      end
      tag_valid <= pick_any & ~win_we;
      tag_idx   <= pick_idx;
    end
  end

  // Gating with rst drops a response whose read was granted just before reset.
  always_comb begin
    if (tag_valid && !rst) begin
      rsp_valid = NUM_REQ'(1) << tag_idx;
    end else begin
      rsp_valid = '0;
    end
    rsp_rdata = ram_q;
  end

endmodule
